gray_counter_param: RTL and testbench
=====================================

Name: gray_counter_param

Overview:
- Parametrised Gray-code counter; successor to the fixed 3-bit up-only Gray counter.
- Adds configurable width, up/down direction, synchronous clear and parallel load, and selectable wrap or saturate at the count bounds.
- Reports overflow and underflow with sticky flags plus a one-cycle terminal pulse.
- Used as a glitch-free position/pointer source (e.g. for FIFO pointers) and as a lab counter block.

Parameters:
- WIDTH, 3, counter width in bits; legal range 2..16.
- SATURATE, 0, bound behaviour: 0 = wrap to the opposite bound; 1 = hold at the bound.

Ports:
- Clk  input  1  rising-edge clock.
- Reset_n  input  1  asynchronous active-low reset.
- Clr  input  1  synchronous clear of count and flags.
- En  input  1  count enable.
- Dir  input  1  direction: 0 = up, 1 = down.
- Load  input  1  synchronous parallel load.
- LoadVal  input  WIDTH  binary value to load.
- Output  output  WIDTH  registered Gray code of the count.
- Binary  output  WIDTH  registered binary count.
- Overflow  output  1  sticky: an up-count was attempted at MAX.
- Underflow  output  1  sticky: a down-count was attempted at 0.
- Term  output  1  one-cycle pulse on any bound event.

Behaviour:
- MAX = 2^WIDTH - 1. All outputs are registered; there is no combinational path from inputs to outputs.
- Reset_n low, asynchronous and independent of Clk: Binary=0, Output=0, Overflow=0, Underflow=0, Term=0. Deassertion takes effect at the next rising edge.
- Per-edge priority: Clr > Load > En.
- Clr=1: Binary=0, Output=0, Overflow=0, Underflow=0, Term=0. Load and En are ignored that cycle.
- Load=1 (Clr=0):
  - Binary=LoadVal; Output=LoadVal ^ (LoadVal>>1).
  - Flags are unchanged; Term=0; En is ignored.
- En=1, Dir=0, Binary<MAX: Binary+1, Term=0.
- En=1, Dir=0, Binary==MAX:
  - Overflow<=1, Term<=1.
  - SATURATE=0: Binary<=0. SATURATE=1: Binary stays MAX.
- En=1, Dir=1, Binary>0: Binary-1, Term=0.
- En=1, Dir=1, Binary==0:
  - Underflow<=1, Term<=1.
  - SATURATE=0: Binary<=MAX. SATURATE=1: Binary stays 0.
- En=0 with no Clr or Load: all state holds; Term<=0.
- Invariant: Output == Binary ^ (Binary>>1) after every edge. Output changes exactly 1 bit per count step, including the wrap step (MAX<->0).
- Arithmetic: WIDTH-bit modulo, with no carry beyond WIDTH. The bound test uses the pre-edge Binary.
- Term is high for exactly one cycle per bound event. With SATURATE=1 and En held at a bound, Term stays high every cycle En is asserted there.
- Overflow and Underflow are independent sticky flags, cleared only by Reset_n or Clr. Both may be 1 at once.
- Dir may change on any cycle; the new direction applies at that edge with no extra latency.
- Reset_n asserted mid-count overrides everything immediately; there is no partial update.

Test Plan:
- Reset, then WIDTH=3, SATURATE=0, En=1, Dir=0 for 9 cycles -> Output 1,3,2,6,7,5,4,0,1; Overflow=1 from the 8th edge; Term=1 only on the 8th edge; Underflow=0.
- From Binary=0, Dir=1, En=1 for 2 cycles -> Binary 7 then 6, Output 4 then 5; Underflow=1 and stays; Term pulses once.
- SATURATE=1, Load LoadVal=6, then En=1, Dir=0 for 3 cycles -> Binary 7,7,7, Output 4; Overflow=1; Term=0,1,1.
- Clr, Load and En all =1 with Overflow=1 -> Binary=0, Output=0, Overflow=0. Next cycle Load=1, En=1, LoadVal=5 -> Binary=5, Output=7, no count.
- Reset_n pulsed low between clock edges mid-count at Binary=5 -> all outputs 0 immediately, before the next edge; after release, counting resumes from 0.
- WIDTH=8 random En/Dir/Load for 2000 cycles against a reference model -> Output == gray(Binary) always; Hamming distance 1 on every count step; flags match the model.

Source files
------------

// File: rtl/gray_counter_param.sv
// gray_counter_param
//   Parametrised up/down Gray-code counter with synchronous clear, parallel
//   load, and wrap-or-saturate behaviour at the count bounds.
//
//   Parameters
//     WIDTH     counter width in bits (2..16)
//     SATURATE  0 = wrap to the opposite bound, 1 = hold at the bound
//
//   Ports
//     Clk        rising-edge clock
//     Reset_n    asynchronous active-low reset
//     Clr        synchronous clear of count and flags (highest priority)
//     En         count enable (lowest priority)
//     Dir        0 = count up, 1 = count down
//     Load       synchronous parallel load of LoadVal
//     LoadVal    binary value to load
//     Output     registered Gray code of the count
//     Binary     registered binary count
//     Overflow   sticky: an up-count was attempted at MAX
//     Underflow  sticky: a down-count was attempted at 0
//     Term       one-cycle pulse on each bound event
module gray_counter_param #(
  parameter int WIDTH    = 3,
  parameter bit SATURATE = 1'b0
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Clr,
  input  logic             En,
  input  logic             Dir,
  input  logic             Load,
  input  logic [WIDTH-1:0] LoadVal,
  output logic [WIDTH-1:0] Output,
  output logic [WIDTH-1:0] Binary,
  output logic             Overflow,
  output logic             Underflow,
  output logic             Term
);

  localparam logic [WIDTH-1:0] MAX  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  logic             at_max, at_zero;
  logic [WIDTH-1:0] bin_inc, bin_dec;
  logic [WIDTH-1:0] bin_nxt, gray_nxt;
  logic             ovf_nxt, unf_nxt, term_nxt;

  assign at_max  = (Binary == MAX);
  assign at_zero = (Binary == ZERO);
  // Modulo WIDTH arithmetic: the wrap values fall out naturally (MAX+1 = 0,
  // 0-1 = MAX), so the wrap case needs no special-cased constant.
  assign bin_inc = Binary + ONE;
  assign bin_dec = Binary - ONE;

  // Next-state selection, priority Clr > Load > En.
  always_comb begin
    bin_nxt  = Binary;
    ovf_nxt  = Overflow;
    unf_nxt  = Underflow;
    term_nxt = 1'b0;
    if (Clr) begin
      bin_nxt = ZERO;
      ovf_nxt = 1'b0;
      unf_nxt = 1'b0;
    end else if (Load) begin
      bin_nxt = LoadVal;
    end else if (En) begin
      if (!Dir) begin
        if (at_max) begin
          ovf_nxt  = 1'b1;
          term_nxt = 1'b1;
          bin_nxt  = SATURATE ? Binary : bin_inc;
        end else begin
          bin_nxt = bin_inc;
        end
      end else begin
        if (at_zero) begin
          unf_nxt  = 1'b1;
          term_nxt = 1'b1;
          bin_nxt  = SATURATE ? Binary : bin_dec;
        end else begin
          bin_nxt = bin_dec;
        end
      end
    end
  end

  // Gray is derived from the next binary value and registered alongside it,
  // so Output is a clean flop output with no decode glitches downstream.
  assign gray_nxt[WIDTH-1] = bin_nxt[WIDTH-1];
  for (genvar i = 0; i < WIDTH-1; i++) begin : g_gray
    assign gray_nxt[i] = bin_nxt[i+1] ^ bin_nxt[i];
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      Binary    <= ZERO;
      Output    <= ZERO;
      Overflow  <= 1'b0;
      Underflow <= 1'b0;
      Term      <= 1'b0;
    end else begin
      Binary    <= bin_nxt;
      Output    <= gray_nxt;
      Overflow  <= ovf_nxt;
      Underflow <= unf_nxt;
      Term      <= term_nxt;
    end
  end

endmodule

// File: tb/tb_gray_counter_param.sv
// Bench for gray_counter_param: three instances (W3 wrap, W3 saturate,
// W8 wrap) share one stimulus stream and are checked every cycle against an
// integer-arithmetic model, plus directed literal checks.
module tb_gray_counter_param;

  logic       Clk = 1'b0;
  logic       Reset_n, Clr, En, Dir, Load;
  logic [7:0] lv;

  logic [2:0] out0, bin0, out1, bin1;
  logic [7:0] out2, bin2;
  logic       ov0, un0, tm0, ov1, un1, tm1, ov2, un2, tm2;

  always #5 Clk = ~Clk;

  gray_counter_param #(.WIDTH(3), .SATURATE(1'b0)) u0 (
    .Clk(Clk), .Reset_n(Reset_n), .Clr(Clr), .En(En), .Dir(Dir), .Load(Load),
    .LoadVal(lv[2:0]), .Output(out0), .Binary(bin0),
    .Overflow(ov0), .Underflow(un0), .Term(tm0));
  gray_counter_param #(.WIDTH(3), .SATURATE(1'b1)) u1 (
    .Clk(Clk), .Reset_n(Reset_n), .Clr(Clr), .En(En), .Dir(Dir), .Load(Load),
    .LoadVal(lv[2:0]), .Output(out1), .Binary(bin1),
    .Overflow(ov1), .Underflow(un1), .Term(tm1));
  gray_counter_param #(.WIDTH(8), .SATURATE(1'b0)) u2 (
    .Clk(Clk), .Reset_n(Reset_n), .Clr(Clr), .En(En), .Dir(Dir), .Load(Load),
    .LoadVal(lv), .Output(out2), .Binary(bin2),
    .Overflow(ov2), .Underflow(un2), .Term(tm2));

  logic [15:0] dout[3], dbin[3];
  logic        dov[3], dun[3], dtm[3];
  assign dout[0] = {13'd0, out0}; assign dbin[0] = {13'd0, bin0};
  assign dout[1] = {13'd0, out1}; assign dbin[1] = {13'd0, bin1};
  assign dout[2] = {8'd0, out2};  assign dbin[2] = {8'd0, bin2};
  assign dov[0] = ov0; assign dun[0] = un0; assign dtm[0] = tm0;
  assign dov[1] = ov1; assign dun[1] = un1; assign dtm[1] = tm1;
  assign dov[2] = ov2; assign dun[2] = un2; assign dtm[2] = tm2;

  int tests = 0;
  int fails = 0;
  bit chk_on = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain integers, bound detected by the unclamped result
  // leaving [0, MAX].
  int cw[3] = '{3, 3, 8};
  bit cs[3] = '{1'b0, 1'b1, 1'b0};
  int          mb[3] = '{0, 0, 0};
  bit          mo[3] = '{0, 0, 0};
  bit          mu[3] = '{0, 0, 0};
  bit          mt[3] = '{0, 0, 0};
  bit          st[3] = '{0, 0, 0};
  logic [15:0] pout[3];

  function automatic int gray(input int b);
    return b ^ (b >> 1);
  endfunction

  always @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int k = 0; k < 3; k++) begin
        mb[k] <= 0; mo[k] <= 0; mu[k] <= 0; mt[k] <= 0; st[k] <= 0;
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        int mx, nb;
        mx = (1 << cw[k]) - 1;
        pout[k] <= dout[k];
        mt[k] <= 1'b0;
        st[k] <= 1'b0;
        if (Clr) begin
          mb[k] <= 0; mo[k] <= 0; mu[k] <= 0;
        end else if (Load) begin
          mb[k] <= int'(lv) & mx;
        end else if (En) begin
          nb = Dir ? mb[k] - 1 : mb[k] + 1;
          if (nb > mx || nb < 0) begin
            mt[k] <= 1'b1;
            if (nb > mx) mo[k] <= 1'b1; else mu[k] <= 1'b1;
            if (cs[k]) nb = mb[k];
            else nb = (nb + mx + 1) % (mx + 1);
          end
          mb[k] <= nb;
          st[k] <= (nb != mb[k]);
        end
      end
    end
  end

  // Every-cycle comparison on the falling edge.
  always @(negedge Clk) begin
    if (chk_on) begin
      for (int k = 0; k < 3; k++) begin
        check($sformatf("bin%0d", k), int'(dbin[k]), mb[k]);
        check($sformatf("gray%0d", k), int'(dout[k]), gray(mb[k]));
        check($sformatf("ovf%0d", k), int'(dov[k]), int'(mo[k]));
        check($sformatf("unf%0d", k), int'(dun[k]), int'(mu[k]));
        check($sformatf("term%0d", k), int'(dtm[k]), int'(mt[k]));
        if (st[k])
          check($sformatf("hamming%0d", k), $countones(dout[k] ^ pout[k]), 1);
      end
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  int exp_up[9] = '{1, 3, 2, 6, 7, 5, 4, 0, 1};

  initial begin
    Reset_n = 1'b1; Clr = 0; En = 0; Dir = 0; Load = 0; lv = 0;
    #2 Reset_n = 1'b0;
    chk_on = 1'b1;
    #1;
    check("rst_bin", int'(bin0), 0);
    check("rst_out", int'(out0), 0);
    check("rst_flags", int'({ov0, un0, tm0}), 0);
    @(posedge Clk); #1;
    Reset_n = 1'b1;

    // Up count through the wrap.
    En = 1; Dir = 0;
    for (int i = 0; i < 9; i++) begin
      tick();
      check("up_gray", int'(out0), exp_up[i]);
      check("up_term", int'(tm0), (i == 7) ? 1 : 0);
      check("up_ovf", int'(ov0), (i >= 7) ? 1 : 0);
      check("up_unf", int'(un0), 0);
    end

    // Down count from 0 wraps to MAX.
    En = 0; Clr = 1; tick();
    Clr = 0; En = 1; Dir = 1;
    tick();
    check("dn_bin_a", int'(bin0), 7);
    check("dn_out_a", int'(out0), 4);
    check("dn_unf_a", int'(un0), 1);
    check("dn_term_a", int'(tm0), 1);
    tick();
    check("dn_bin_b", int'(bin0), 6);
    check("dn_out_b", int'(out0), 5);
    check("dn_unf_b", int'(un0), 1);
    check("dn_term_b", int'(tm0), 0);

    // Saturation at MAX.
    En = 0; Load = 1; lv = 8'd6; tick();
    Load = 0; En = 1; Dir = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("sat_bin", int'(bin1), 7);
      check("sat_out", int'(out1), 4);
      check("sat_term", int'(tm1), (i == 0) ? 0 : 1);
    end
    check("sat_ovf", int'(ov1), 1);
    check("pre_clr_ovf", int'(ov0), 1);

    // Priority: Clr over Load/En, then Load over En.
    Clr = 1; Load = 1; En = 1; lv = 8'd3; tick();
    check("clr_bin", int'(bin0), 0);
    check("clr_out", int'(out0), 0);
    check("clr_flags", int'({ov0, un0}), 0);
    Clr = 0; Load = 1; En = 1; lv = 8'd5; tick();
    check("ld_bin", int'(bin0), 5);
    check("ld_out", int'(out0), 7);

    // Asynchronous reset between edges.
    Load = 0; En = 0;
    #2 Reset_n = 1'b0;
    #1;
    check("arst_bin", int'(bin0), 0);
    check("arst_out", int'(out0), 0);
    check("arst_bin8", int'(bin2), 0);
    Reset_n = 1'b1;
    En = 1; Dir = 0;
    tick();
    check("resume_bin", int'(bin0), 1);
    check("resume_out", int'(out0), 1);

    // Randomised traffic; the W8 instance gets the full LoadVal range.
    for (int i = 0; i < 2000; i++) begin
      En   = ($urandom_range(0, 3) != 0);
      Dir  = $urandom_range(0, 1);
      Load = ($urandom_range(0, 15) == 0);
      Clr  = ($urandom_range(0, 63) == 0);
      lv   = 8'($urandom_range(0, 255));
      tick();
    end
    Clr = 0; Load = 0; En = 0;
    tick(); tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
